// File: rtl/mem_arb_if.sv
// mem_arb_if: requester handshakes and memory port of the fetch/data memory arbiter
interface mem_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_done;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  // master is the arbiter, which owns the memory port and answers both requesters
  modport master (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_done, f_rdata, d_done, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  // slave is the surrounding datapath plus the memory itself
  modport slave (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_done, f_rdata, d_done, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter serializing fetch and data accesses onto one memory port
module mem_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input logic       clk,
  input logic       rst_f,
  mem_arb_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [3:0] CNT_LAST = 4'(LAT - 1);
  state_t            state, state_nx;
  logic              owner;
  logic              last_grant;
  logic              we;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, f_rdata, d_rdata;
  logic              req, grant_d, last;
  // owner/last_grant use 1 for the data requester; D wins a tie only if F was served last
  assign req     = bus.f_req || bus.d_req;
  assign grant_d = bus.d_req && (!bus.f_req || !last_grant);
  assign last    = cnt == CNT_LAST;
  // state register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= IDLE;
    else        state <= state_nx;
  end
  // next state and memory/handshake outputs, all decoded from the current state
  always_comb begin
    state_nx      = (state == IDLE) ? (req ? BUSY : IDLE) : (state == BUSY) ? (last ? RESP : BUSY) : IDLE;
    bus.busy      = state != IDLE;
    bus.mem_en    = state == BUSY;
    bus.mem_we    = state == BUSY && we;
    bus.mem_addr  = (state == BUSY) ? addr : '0;
    bus.mem_wdata = (state == BUSY) ? wdata : '0;
    bus.f_done    = state == RESP && !owner;
    bus.d_done    = state == RESP && owner;
    bus.f_rdata   = f_rdata;
    bus.d_rdata   = d_rdata;
  end
  // latch the granted request, count access cycles, capture read data, remember the winner
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      we         <= 1'b0;
      cnt        <= '0;
      addr       <= '0;
      wdata      <= '0;
      f_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      if (state == IDLE && req) begin
        owner <= grant_d;
        addr  <= grant_d ? bus.d_addr : bus.f_addr;
        we    <= grant_d && bus.d_we;
        wdata <= grant_d ? bus.d_wdata : '0;
        cnt   <= '0;
      end
      if (state == BUSY) begin
        cnt <= cnt + 4'd1;
        if (last && !owner) f_rdata <= bus.mem_rdata;
        if (last && owner && !we) d_rdata <= bus.mem_rdata;
      end
      if (state == RESP) last_grant <= owner;
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb with a latency-exact memory model
module tb_mem_arb;
  localparam int LAT = 3;
  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mem [256];
  logic [3:0]  en_cnt = 4'd0;
  mem_arb_if #(.ADDR_W(8), .DATA_W(32)) bus ();
  mem_arb #(.ADDR_W(8), .DATA_W(32), .LAT(LAT)) dut (.clk(clk), .rst_f(rst_f), .bus(bus));
  always #5 clk = ~clk;
  // read data is only valid in the LAT-th enabled cycle; anything else returns a poison word
  assign bus.mem_rdata = (bus.mem_en && en_cnt == 4'(LAT - 1)) ? mem[bus.mem_addr] : 32'hDEAD_BEEF;
  always @(posedge clk) en_cnt <= bus.mem_en ? en_cnt + 4'd1 : 4'd0;
  always @(posedge clk) if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
  // pop the scoreboard on every done pulse and compare owner and returned data
  always @(negedge clk) begin
    if (bus.f_done || bus.d_done) begin
      checks++;
      if (bus.f_done && bus.d_done) begin
        errors++;
        $display("FAIL done_overlap: f_done=1 and d_done=1 in the same cycle, required at most one");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: f_done=%0b d_done=%0b, required no done", bus.f_done, bus.d_done);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_d !== bus.d_done ||
            (!mon_e.we && (mon_e.is_d ? bus.d_rdata : bus.f_rdata) !== mon_e.data)) begin
          errors++;
          $display("FAIL sb_done: got owner_d=%0b rdata=%h, required owner_d=%0b rdata=%h (addr %h we %0b)",
                   bus.d_done, mon_e.is_d ? bus.d_rdata : bus.f_rdata, mon_e.is_d, mon_e.data,
                   mon_e.addr, mon_e.we);
        end
      end
    end
  end
  task automatic wait_done(input bit want_d, output int n, output int en, output int we);
    n = 0;
    en = 0;
    we = 0;
    do begin
      @(negedge clk);
      n++;
      en += int'(bus.mem_en);
      we += int'(bus.mem_we);
    end while (!(want_d ? bus.d_done : bus.f_done) && n < 60);
    if (!(want_d ? bus.d_done : bus.f_done)) n = -1;
  endtask
  task automatic pulse_reset;
    @(posedge clk); #1;
    rst_f = 1'b0;
    @(posedge clk); #1;
    rst_f = 1'b1;
  endtask
  task automatic test_reset;
    rst_f = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.mem_en, bus.mem_we, bus.f_done, bus.d_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy,en,we,f_done,d_done=%b, required 00000",
               {bus.busy, bus.mem_en, bus.mem_we, bus.f_done, bus.d_done});
    end
    checks++;
    if (bus.mem_addr !== 8'h0 || bus.mem_wdata !== 32'h0 || bus.f_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h f_rdata=%h d_rdata=%h, required all 0",
               bus.mem_addr, bus.mem_wdata, bus.f_rdata, bus.d_rdata);
    end
    @(posedge clk); #1;
    rst_f = 1'b1;
  endtask
  task automatic test_fetch;
    int n, en, we;
    mem[8'h10] = 32'h1122_3344;
    @(posedge clk); #1;
    bus.f_addr = 8'h10;
    bus.f_req = 1'b1;
    sb.push_back({1'b0, 1'b0, 8'h10, 32'h1122_3344});
    wait_done(1'b0, n, en, we);
    bus.f_req = 1'b0;
    checks++;
    if (n !== LAT + 2) begin
      errors++;
      $display("FAIL fetch_latency: done in cycle %0d counting the grant cycle as 1, required %0d", n, LAT + 2);
    end
    checks++;
    if (en !== LAT || we !== 0) begin
      errors++;
      $display("FAIL fetch_mem_cycles: mem_en=%0d mem_we=%0d cycles, required %0d and 0", en, we, LAT);
    end
  endtask
  task automatic test_tie_store;
    int n, en, we;
    pulse_reset();
    bus.f_addr = 8'h10;
    bus.d_addr = 8'h20;
    bus.d_we = 1'b1;
    bus.d_wdata = 32'hCAFE_F00D;
    bus.f_req = 1'b1;
    bus.d_req = 1'b1;
    sb.push_back({1'b0, 1'b0, 8'h10, 32'h1122_3344});
    sb.push_back({1'b1, 1'b1, 8'h20, 32'hCAFE_F00D});
    wait_done(1'b0, n, en, we);
    bus.f_req = 1'b0;
    checks++;
    if (n !== LAT + 2 || we !== 0) begin
      errors++;
      $display("FAIL tie_f_first: f_done at cycle %0d with %0d write cycles, required %0d and 0", n, we, LAT + 2);
    end
    wait_done(1'b1, n, en, we);
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    checks++;
    if (n !== LAT + 2 || we !== LAT) begin
      errors++;
      $display("FAIL tie_d_store: d_done after %0d cycles with %0d write cycles, required %0d and %0d",
               n, we, LAT + 2, LAT);
    end
    checks++;
    if (mem[8'h20] !== 32'hCAFE_F00D || bus.d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL store_result: mem[20]=%h d_rdata=%h, required cafef00d and 0", mem[8'h20], bus.d_rdata);
    end
  endtask
  task automatic test_back_to_back;
    int n, en, we;
    mem[8'h30] = 32'hA0A0_A0A0;
    mem[8'h40] = 32'hB1B1_B1B1;
    @(posedge clk); #1;
    bus.f_addr = 8'h30;
    bus.d_addr = 8'h40;
    bus.d_we = 1'b0;
    bus.f_req = 1'b1;
    bus.d_req = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back(k[0] ? {1'b1, 1'b0, 8'h40, 32'hB1B1_B1B1} : {1'b0, 1'b0, 8'h30, 32'hA0A0_A0A0});
    for (int k = 0; k < 4; k++) begin
      wait_done(k[0], n, en, we);
      checks++;
      if (n !== LAT + 2) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: done after %0d cycles, required %0d", k, n, LAT + 2);
      end
    end
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
  endtask
  task automatic test_req_drop;
    int n, en, we, extra;
    mem[8'h50] = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.d_addr = 8'h50;
    bus.d_we = 1'b0;
    bus.d_req = 1'b1;
    sb.push_back({1'b1, 1'b0, 8'h50, 32'h5555_AAAA});
    @(negedge clk);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    bus.d_addr = 8'h99;
    bus.d_we = 1'b1;
    wait_done(1'b1, n, en, we);
    checks++;
    if (n !== LAT + 1 || en !== LAT || we !== 0) begin
      errors++;
      $display("FAIL drop_complete: n=%0d en=%0d we=%0d, required %0d %0d 0", n, en, we, LAT + 1, LAT);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      extra += int'(bus.d_done || bus.f_done);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL drop_single_done: %0d further done pulses, required 0", extra);
    end
    @(posedge clk); #1;
    bus.d_addr = 8'h51;
    bus.d_wdata = 32'h1234_5678;
    bus.d_we = 1'b1;
    bus.d_req = 1'b1;
    sb.push_back({1'b1, 1'b1, 8'h51, 32'h1234_5678});
    wait_done(1'b1, n, en, we);
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    checks++;
    if (bus.d_rdata !== 32'h5555_AAAA || mem[8'h51] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL store_keeps_rdata: d_rdata=%h mem[51]=%h, required 5555aaaa and 12345678",
               bus.d_rdata, mem[8'h51]);
    end
  endtask
  task automatic test_reset_abort;
    int n, en, we;
    mem[8'h60] = 32'h6666_6666;
    @(posedge clk); #1;
    bus.f_addr = 8'h10;
    bus.f_req = 1'b1;
    sb.push_back({1'b0, 1'b0, 8'h10, 32'h1122_3344});
    wait_done(1'b0, n, en, we);
    bus.f_req = 1'b0;
    @(posedge clk); #1;
    bus.d_addr = 8'h60;
    bus.d_we = 1'b0;
    bus.d_req = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.f_req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: mem_en=%b mid-access, required 1", bus.mem_en);
    end
    #2;
    rst_f = 1'b0;
    #1;
    checks++;
    if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_now: mem_en=%b mem_we=%b busy=%b, required 0 0 0", bus.mem_en, bus.mem_we, bus.busy);
    end
    @(posedge clk); #1;
    rst_f = 1'b1;
    sb.push_back({1'b0, 1'b0, 8'h10, 32'h1122_3344});
    sb.push_back({1'b1, 1'b0, 8'h60, 32'h6666_6666});
    wait_done(1'b0, n, en, we);
    bus.f_req = 1'b0;
    checks++;
    if (n !== LAT + 2) begin
      errors++;
      $display("FAIL abort_f_first: f_done at cycle %0d after release, required %0d", n, LAT + 2);
    end
    wait_done(1'b1, n, en, we);
    bus.d_req = 1'b0;
    checks++;
    if (n !== LAT + 2) begin
      errors++;
      $display("FAIL abort_d_next: d_done after %0d cycles, required %0d", n, LAT + 2);
    end
  endtask
  task automatic test_idle;
    int bad;
    bad = 0;
    @(posedge clk); #1;
    repeat (10) begin
      @(negedge clk);
      bad += int'(bus.busy || bus.mem_en || bus.f_done || bus.d_done);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d active cycles, required 0", bad);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_drained: %0d expected accesses never completed, required 0", sb.size());
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0101_0101 * i;
    bus.f_req = 1'b0;
    bus.f_addr = 8'h0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = 8'h0;
    bus.d_wdata = 32'h0;
    test_reset();
    test_fetch();
    test_tie_store();
    test_back_to_back();
    test_req_drop();
    test_reset_abort();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
